lcd_cmd_arbiter: RTL and testbench
==================================

# lcd_cmd_arbiter

Two-port arbiter that shares the single character-LCD write engine (`LCD_Controller`: 8-bit data, RS, start/done handshake) between two independent requesters, for example a boot-time init/text sequencer and a run-time status writer. It grants round-robin and issues one 9-bit command (RS + data) at a time. After each command it enforces the mandatory LCD settle delay, longer for clear/home commands, and then acknowledges the requester. A watchdog recovers from a write engine that never signals done.

## Interface
- `DLY_CYCLES`, 2500: settle cycles after a normal command (50 µs at 50 MHz); legal range 1..262143.
- `LONG_DLY_CYCLES`, 100000: settle cycles after clear/home (2 ms at 50 MHz); legal range 1..262143.
- `TIMEOUT_CYCLES`, 65535: maximum cycles to wait for `iLCD_Done`; legal range 1..262143.
- `iCLK`  in  1  system clock; single clock domain.
- `iRST_N`  in  1  asynchronous, active-low reset.
- `iREQ`  in  2  per-port request, level, held until the matching `oACK`.
- `iCMD0`  in  9  port 0 command: [8]=RS, [7:0]=data; stable while `iREQ[0]` is high.
- `iCMD1`  in  9  port 1 command, same format.
- `oACK`  out  2  one-cycle completion pulse per port.
- `oBUSY`  out  1  high whenever the state is not IDLE.
- `oERR`  out  1  one-cycle pulse on watchdog expiry.
- `oLCD_DATA`  out  8  data to the write engine.
- `oLCD_RS`  out  1  RS to the write engine.
- `oLCD_Start`  out  1  start level to the write engine.
- `iLCD_Done`  in  1  write-engine done.

## Operation
- **States:** IDLE, WAIT_DONE, DELAY, ACK. Encoding is free.
- **Reset values:** state=IDLE, `oACK`=0, `oBUSY`=0, `oERR`=0, `oLCD_DATA`=0, `oLCD_RS`=0, `oLCD_Start`=0, counter=0, last-served pointer=1 (so port 0 wins first).
- **IDLE:**
  - If no `iREQ` bit is set, stay in IDLE.
  - If exactly one bit is set, grant that port.
  - If both bits are set, grant the port that is not the last-served port.
  - On grant: latch the granted command into `oLCD_RS`/`oLCD_DATA`, set `oLCD_Start`=1, record the granted port, load the counter with TIMEOUT_CYCLES-1, go to WAIT_DONE.
- **WAIT_DONE:**
  - If `iLCD_Done`=1: set `oLCD_Start`=0, load the counter with the settle value, go to DELAY.
  - Otherwise, if counter=0: set `oLCD_Start`=0, pulse `oERR`, load the counter with LONG_DLY_CYCLES-1, go to DELAY.
  - Otherwise decrement the counter.
  - `iLCD_Done` takes priority when it arrives on the same edge as the timeout.
- **Settle value:** LONG_DLY_CYCLES-1 when RS=0, data[7:2]=0 and data[1:0]≠0 (0x01 clear, 0x02/0x03 home); DLY_CYCLES-1 for every other command.
- **DELAY:** when counter=0, go to ACK; otherwise decrement.
- **ACK:** `oACK[g]`=1 for this cycle only, update the last-served pointer to g, return to IDLE.
- **Command stability:** the latched command must not change after the grant, even if the requester changes `iCMDn`.
- **Request dropped after grant:** the command still completes and the ack is still pulsed.
- **Request dropped before grant:** nothing is issued.
- **Re-request:** a requester that keeps `iREQ` high after its ack is treated as a new request. It re-competes in round-robin from IDLE.
- **Counter:** a single 18-bit down-counter serves both timeout and settle; no wrap-around is allowed.
- **Reset mid-operation:** all outputs return to their reset values immediately. The in-flight command gets no ack and is not retried.

## Timing
- **Request to start:** `iREQ` sampled high at IDLE edge t, then `oLCD_Start`=1 from t onward, i.e. visible in cycle t+1.
- **Done to start low:** `iLCD_Done` sampled at edge u, then `oLCD_Start`=0 after u. DELAY occupies exactly D = settle-parameter cycles. `oACK` is high for the single cycle after DELAY.
- **Done to ack latency:** D+1 cycles. `oBUSY` falls the same edge `oACK` falls.
- **Back-to-back commands:** the earliest next `oLCD_Start` is 1 cycle after the `oACK` cycle (IDLE evaluation).
- **Timeout:** `oERR` fires TIMEOUT_CYCLES cycles after `oLCD_Start` rises, if no done arrives.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single port 0 request:** `iCMD0`=9'h138 with a stub done 5 cycles after start. Expect: `oLCD_DATA`=0x38, `oLCD_RS`=0; `oACK[0]` exactly DLY_CYCLES+1 cycles after done; `oBUSY` high throughout.
- **Both ports hold requests from reset:** `iCMD0`=9'h141, `iCMD1`=9'h142. Expect the issue order 0x41, 0x42, 0x41, 0x42; each ack pulses exactly once per command.
- **Clear vs write settle:** port 1 sends 9'h001, then 9'h101. Expect a LONG_DLY_CYCLES settle after the clear (RS=0) and a DLY_CYCLES settle after 0x01 with RS=1.
- **Stalled write engine:** hold `iLCD_Done`=0 with TIMEOUT_CYCLES=100. Expect: `oERR` pulses 100 cycles after start; `oLCD_Start` drops; `oACK` follows after LONG_DLY_CYCLES+1 cycles.
- **Mid-operation disturbance:** drop `iREQ[0]` and change `iCMD0` during WAIT_DONE. Expect `oLCD_DATA` to be unchanged and `oACK[0]` to be delivered.
- **Reset during DELAY:** assert `iRST_N`=0 during DELAY. Expect all outputs 0 asynchronously, no ack, and port 0 granted first after release.

Source files
------------

// File: rtl/lcd_cmd_arbiter.sv
`timescale 1ns/1ps
// lcd_cmd_arbiter: round-robin sharing of one LCD write engine between two
// requesters, with post-command settle delay and a done-watchdog.
module lcd_cmd_arbiter #(
    parameter int DLY_CYCLES      = 2500,
    parameter int LONG_DLY_CYCLES = 100000,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [1:0] iREQ,
    input  logic [8:0] iCMD0,
    input  logic [8:0] iCMD1,
    output logic [1:0] oACK,
    output logic       oBUSY,
    output logic       oERR,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    input  logic       iLCD_Done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        DELAY,
        ACK
    } state_t;

    localparam logic [17:0] DLY_M1  = 18'(DLY_CYCLES - 1);
    localparam logic [17:0] LONG_M1 = 18'(LONG_DLY_CYCLES - 1);
    localparam logic [17:0] TO_M1   = 18'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [17:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        start_q, start_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [1:0]  ack_q, ack_d;

    logic        sel;
    logic [8:0]  cmd_sel;
    logic        long_cmd;

    // Next-state logic: grant, wait for done or timeout, settle, acknowledge.
    always_comb begin
        sel      = (iREQ == 2'b11) ? ~last_q : ~iREQ[0];
        cmd_sel  = sel ? iCMD1 : iCMD0;
        long_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        start_d = start_q;
        err_d   = 1'b0;
        ack_d   = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (|iREQ) begin
                    gnt_d   = sel;
                    rs_d    = cmd_sel[8];
                    data_d  = cmd_sel[7:0];
                    start_d = 1'b1;
                    cnt_d   = TO_M1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (iLCD_Done) begin
                    start_d = 1'b0;
                    cnt_d   = long_cmd ? LONG_M1 : DLY_M1;
                    state_d = DELAY;
                end else if (cnt_q == 18'd0) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = LONG_M1;
                    state_d = DELAY;
                end else begin
                    cnt_d = cnt_q - 18'd1;
                end
            end
            DELAY: begin
                if (cnt_q == 18'd0) begin
                    ack_d   = gnt_q ? 2'b10 : 2'b01;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 18'd1;
                end
            end
            ACK: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any in-flight command.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= 18'd0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            data_q  <= 8'd0;
            rs_q    <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            start_q <= start_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign oACK       = ack_q;
    assign oBUSY      = busy_q;
    assign oERR       = err_q;
    assign oLCD_DATA  = data_q;
    assign oLCD_RS    = rs_q;
    assign oLCD_Start = start_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
`timescale 1ns/1ps
// tb_lcd_cmd_arbiter: randomized requesters and done stub, transaction-level
// reference model feeding a scoreboard checked by an independent monitor.
module tb_lcd_cmd_arbiter;

    localparam int DLY = 7;
    localparam int LNG = 23;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [8:0] cmd [2];
    logic       done;
    logic [1:0] ack;
    logic       busy, err, rs, start;
    logic [7:0] data;

    lcd_cmd_arbiter #(
        .DLY_CYCLES(DLY),
        .LONG_DLY_CYCLES(LNG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .iCLK(clk),
        .iRST_N(rst_n),
        .iREQ(req),
        .iCMD0(cmd[0]),
        .iCMD1(cmd[1]),
        .oACK(ack),
        .oBUSY(busy),
        .oERR(err),
        .oLCD_DATA(data),
        .oLCD_RS(rs),
        .oLCD_Start(start),
        .iLCD_Done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         port;
        logic [8:0] cmd;
        int         g;
        bit         to;
        int         e;
        int         a;
    } txn_t;

    txn_t q[$];

    int checks = 0;
    int passes = 0;
    bit mon_en = 0;

    bit inflight [2];
    int ackat [2];
    int m_free, m_done, m_last, n_grants, busy_until, cur_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h",
                      nm, cyc, act, exp);
    endtask

    function automatic logic [8:0] rnd_cmd();
        case ($urandom_range(0, 7))
            0: return 9'h001;
            1: return 9'h002;
            2: return 9'h003;
            3: return 9'h101;
            4: return 9'h004;
            default: return 9'($urandom);
        endcase
    endfunction

    // Clear (0x01) and home (0x02, 0x03) with RS low need the long settle.
    function automatic int settle(input logic [8:0] c);
        if (c[8] == 1'b0 && c[7:0] >= 8'd1 && c[7:0] <= 8'd3) return LNG;
        return DLY;
    endfunction

    // Monitor: compare every output against the front expected transaction.
    always @(negedge clk) begin : mon
        txn_t       f;
        bit         have;
        int         n;
        logic [1:0] e_ack;
        if (mon_en) begin
            n    = cyc;
            have = (q.size() != 0);
            if (have) f = q[0];
            e_ack = (have && n == f.a) ? (f.port == 1 ? 2'b10 : 2'b01) : 2'b00;
            chk("ack", ack, e_ack);
            chk("busy", busy, (have && n >= f.g && n <= f.a) ? 1 : 0);
            chk("err", err, (have && f.to && n == f.e) ? 1 : 0);
            chk("start", start, (have && n >= f.g && n < f.e) ? 1 : 0);
            if (have && n >= f.g && n <= f.a) begin
                chk("lcd_data", data, f.cmd[7:0]);
                chk("lcd_rs", rs, f.cmd[8]);
            end
            if (have && n >= f.a) void'(q.pop_front());
        end
    end

    // One cycle of stimulus plus the transaction-level arbiter model.
    task automatic step(input bit rnd);
        int   n, w, k;
        bit   to;
        txn_t t;
        n = cyc;
        for (int p = 0; p < 2; p++) begin
            if (inflight[p] && n >= ackat[p]) begin
                inflight[p] = 0;
                if (rnd) begin
                    if ($urandom_range(0, 1) == 1) cmd[p] = rnd_cmd();
                    else req[p] = 1'b0;
                end
            end else if (rnd) begin
                if (inflight[p]) begin
                    if ($urandom_range(0, 15) == 0) req[p] = 1'b0;
                    if ($urandom_range(0, 15) == 0) cmd[p] = rnd_cmd();
                end else if (!req[p]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[p] = 1'b1;
                        cmd[p] = rnd_cmd();
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req[p] = 1'b0;
                end
            end
        end
        if (n + 1 >= m_free) begin
            if (req == 2'b00) begin
                m_free = n + 2;
            end else begin
                if (req == 2'b11) w = 1 - m_last;
                else w = req[1] ? 1 : 0;
                to = rnd && ($urandom_range(0, 7) == 0);
                if (to) begin
                    t.e = n + 1 + TMO;
                end else begin
                    k = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(1, 12);
                    t.e = n + 1 + k;
                    m_done = t.e;
                end
                t.port = w;
                t.cmd  = cmd[w];
                t.g    = n + 1;
                t.to   = to;
                t.a    = t.e + (to ? LNG : settle(cmd[w]));
                q.push_back(t);
                inflight[w] = 1;
                ackat[w]    = t.a;
                m_last      = w;
                m_free      = t.a + 2;
                busy_until  = t.a;
                cur_e       = t.e;
                n_grants++;
            end
        end
        done = (n + 1 == m_done);
    endtask

    task automatic tick(input bit rnd);
        step(rnd);
        @(negedge clk);
        #1;
    endtask

    task automatic run_grants(input int nt);
        int target, guard;
        target = n_grants + nt;
        guard  = 0;
        while (n_grants < target && guard < 2000) begin
            tick(0);
            guard++;
        end
        chk("grant_bound", (guard < 2000) ? 1 : 0, 1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (cyc <= busy_until + 1 && guard < 2000) begin
            tick(0);
            guard++;
        end
        chk("drain_bound", (guard < 2000) ? 1 : 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_rs"}, rs, 0);
        chk({tag, "_start"}, start, 0);
    endtask

    task automatic clear_model();
        q.delete();
        inflight[0] = 0;
        inflight[1] = 0;
        m_done      = -1;
        m_last      = 1;
        done        = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n      = 1'b0;
        req        = 2'b00;
        cmd[0]     = 9'h000;
        cmd[1]     = 9'h000;
        n_grants   = 0;
        busy_until = 0;
        cur_e      = 0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");

        cmd[0] = 9'h141;
        cmd[1] = 9'h142;
        req    = 2'b11;
        rst_n  = 1'b1;
        m_free = cyc + 1;
        mon_en = 1;
        run_grants(4);
        req = 2'b00;
        drain();

        repeat (4000) tick(1);
        req = 2'b00;
        drain();

        cmd[0] = 9'h138;
        req    = 2'b01;
        run_grants(1);
        req = 2'b00;
        drain();

        cmd[0] = 9'h141;
        cmd[1] = 9'h142;
        req    = 2'b11;
        run_grants(1);
        guard = 0;
        while (cyc < cur_e + 2 && guard < 500) begin
            tick(0);
            guard++;
        end
        chk("delay_bound", (guard < 500) ? 1 : 0, 1);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        chk_zero("midrst");
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        m_free = cyc + 1;
        mon_en = 1;
        run_grants(2);
        req = 2'b00;
        drain();

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
